// File: rtl/alu_8bit_pb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_8bit_pb_if
// Description : Switch/button/LED bundle for the pushbutton ALU board top.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_8bit_pb_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] PB;
  logic [7:0] led;

  modport master (
    output a,
    output b,
    output PB,
    input  led
  );

  modport slave (
    input  a,
    input  b,
    input  PB,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/alu_8bit_pb.sv
`default_nettype none
// ============================================================================
// Module      : alu_8bit_pb
// Description : 8-operation 8-bit ALU; PB[0] steps the op, PB[1] toggles the
//               LED view between the result and {op,0,C,Z,N,V}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8bit_pb #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_8bit_pb_if.slave  bus
);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_NOT = 3'd5;
  localparam logic [2:0] c_OP_SHL = 3'd6;
  localparam logic [2:0] c_OP_SHR = 3'd7;

  // Presses are ignored until the synchronizer and prev flop have both seen
  // real button levels, so a button held through reset never fires.
  localparam int c_SETTLE = SYNC_STAGES + 1;
  localparam int c_SW     = $clog2(c_SETTLE + 1);

  // Asynchronous assert, synchronous release of the internal reset.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]                  r_prev;
  logic [c_SW-1:0]             r_settle;
  logic [1:0]                  w_sync_out;
  logic                        w_armed;
  logic [1:0]                  w_press;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_armed    = (r_settle == c_SW'(c_SETTLE));
  assign w_press    = w_sync_out & ~r_prev & {2{w_armed}};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync   <= '0;
      r_prev   <= 2'b00;
      r_settle <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.PB};
      r_prev <= w_sync_out;
      if (!w_armed) r_settle <= r_settle + c_SW'(1);
    end
  end

  logic [2:0] r_op;
  logic       r_view;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_op   <= 3'd0;
      r_view <= 1'b0;
    end else begin
      if (w_press[0]) r_op   <= r_op + 3'd1;
      if (w_press[1]) r_view <= ~r_view;
    end
  end

  logic [8:0] w_sum9;
  logic [8:0] w_diff9;
  logic [7:0] w_res;
  logic       w_c;
  logic       w_v;

  assign w_sum9  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff9 = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    w_res = 8'h00;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_res = w_sum9[7:0];
        w_c   = w_sum9[8];
        w_v   = (bus.a[7] == bus.b[7]) && (w_sum9[7] != bus.a[7]);
      end
      c_OP_SUB: begin
        w_res = w_diff9[7:0];
        // The 9th bit of the zero-extended difference is the unsigned borrow.
        w_c   = w_diff9[8];
        w_v   = (bus.a[7] != bus.b[7]) && (w_diff9[7] != bus.a[7]);
      end
      c_OP_AND: w_res = bus.a & bus.b;
      c_OP_OR:  w_res = bus.a | bus.b;
      c_OP_XOR: w_res = bus.a ^ bus.b;
      c_OP_NOT: w_res = ~bus.a;
      c_OP_SHL: begin
        w_res = {bus.a[6:0], 1'b0};
        w_c   = bus.a[7];
      end
      c_OP_SHR: begin
        w_res = {1'b0, bus.a[7:1]};
        w_c   = bus.a[0];
      end
      default: w_res = 8'h00;
    endcase
  end

  logic [7:0] r_res;
  logic [3:0] r_flags;
  logic [2:0] r_op_q;
  logic [7:0] r_led;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_res   <= 8'h00;
      r_flags <= 4'h0;
      r_op_q  <= 3'd0;
      r_led   <= 8'h00;
    end else begin
      r_res   <= w_res;
      r_flags <= {w_c, (w_res == 8'h00), w_res[7], w_v};
      r_op_q  <= r_op;
      r_led   <= r_view ? {r_op_q, 1'b0, r_flags} : r_res;
    end
  end

  assign bus.led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_alu_8bit_pb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_8bit_pb
// Description : Directed self-checking bench for alu_8bit_pb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8bit_pb;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_8bit_pb_if bus ();

  alu_8bit_pb #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle button pulse, then enough clocks for sync, edge, state, led.
  task automatic press(input logic [1:0] mask);
    bus.PB = mask;
    cycles(1);
    bus.PB = 2'b00;
    cycles(7);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.a  = 8'h12;
    bus.b  = 8'h34;
    bus.PB = 2'b00;
    cycles(3);
    n_tests++;
    if (bus.led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_led: led=%h expected 00", bus.led);
    end
    rst_n = 1'b1;
    cycles(10);
    n_tests++;
    if (bus.led !== 8'h46) begin
      n_fail++;
      $display("FAIL add_12_34: led=%h expected 46", bus.led);
    end
    press(2'b10);
    n_tests++;
    if (bus.led !== 8'h00) begin
      n_fail++;
      $display("FAIL flags_12_34: led=%h expected 00", bus.led);
    end
    press(2'b10);
  endtask

  task automatic test_add_flags();
    bus.a = 8'h7F;
    bus.b = 8'h01;
    cycles(4);
    n_tests++;
    if (bus.led !== 8'h80) begin
      n_fail++;
      $display("FAIL add_7f_01: led=%h expected 80", bus.led);
    end
    press(2'b10);
    n_tests++;
    if (bus.led !== 8'h03) begin
      n_fail++;
      $display("FAIL flags_7f_01: led=%h expected 03", bus.led);
    end
    bus.a = 8'hFF;
    bus.b = 8'h01;
    cycles(4);
    n_tests++;
    if (bus.led !== 8'h0C) begin
      n_fail++;
      $display("FAIL flags_ff_01: led=%h expected 0c", bus.led);
    end
    press(2'b10);
    n_tests++;
    if (bus.led !== 8'h00) begin
      n_fail++;
      $display("FAIL add_ff_01: led=%h expected 00", bus.led);
    end
  endtask

  task automatic test_op_step();
    logic [7:0] exp_res [8];
    exp_res = '{8'hB4, 8'h03, 8'hCF, 8'hCC, 8'h3C, 8'h86, 8'h61, 8'hD2};
    bus.a = 8'hC3;
    bus.b = 8'h0F;
    cycles(4);
    for (int i = 0; i < 8; i++) begin
      press(2'b01);
      n_tests++;
      if (bus.led !== exp_res[i]) begin
        n_fail++;
        $display("FAIL op_step_%0d: led=%h expected %h", (i + 1) % 8, bus.led, exp_res[i]);
      end
      if (i == 5 || i == 6) begin
        press(2'b10);
        n_tests++;
        if (bus.led !== ((i == 5) ? 8'hCA : 8'hE8)) begin
          n_fail++;
          $display("FAIL op_step_%0d_flags: led=%h expected %h", i + 1, bus.led,
                   (i == 5) ? 8'hCA : 8'hE8);
        end
        press(2'b10);
      end
    end
  endtask

  task automatic test_hold();
    bus.PB = 2'b01;
    cycles(50);
    bus.PB = 2'b00;
    cycles(8);
    n_tests++;
    if (bus.led !== 8'hB4) begin
      n_fail++;
      $display("FAIL hold_once: led=%h expected b4", bus.led);
    end
  endtask

  task automatic test_sub_borrow();
    bus.a = 8'h05;
    bus.b = 8'h07;
    cycles(4);
    n_tests++;
    if (bus.led !== 8'hFE) begin
      n_fail++;
      $display("FAIL sub_05_07: led=%h expected fe", bus.led);
    end
    press(2'b10);
    n_tests++;
    if (bus.led !== 8'h2A) begin
      n_fail++;
      $display("FAIL sub_05_07_flags: led=%h expected 2a", bus.led);
    end
    press(2'b10);
  endtask

  task automatic test_both_buttons();
    bus.a = 8'hC3;
    bus.b = 8'h0F;
    cycles(4);
    press(2'b11);
    n_tests++;
    if (bus.led !== 8'h40) begin
      n_fail++;
      $display("FAIL both_buttons: led=%h expected 40", bus.led);
    end
    press(2'b10);
    n_tests++;
    if (bus.led !== 8'h03) begin
      n_fail++;
      $display("FAIL both_buttons_result: led=%h expected 03", bus.led);
    end
  endtask

  task automatic test_reset_mid();
    bus.PB = 2'b01;
    cycles(3);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.led !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_led: led=%h expected 00", bus.led);
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    n_tests++;
    if (bus.led !== 8'hD2) begin
      n_fail++;
      $display("FAIL held_through_reset: led=%h expected d2", bus.led);
    end
    bus.PB = 2'b00;
    cycles(8);
    n_tests++;
    if (bus.led !== 8'hD2) begin
      n_fail++;
      $display("FAIL release_after_reset: led=%h expected d2", bus.led);
    end
    press(2'b01);
    n_tests++;
    if (bus.led !== 8'hB4) begin
      n_fail++;
      $display("FAIL repress_after_reset: led=%h expected b4", bus.led);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.a   = 8'h00;
    bus.b   = 8'h00;
    bus.PB  = 2'b00;
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_op_step();
    test_hold();
    test_sub_borrow();
    test_both_buttons();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
